// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick timer: FSM state encoding and mode values.
package tick_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..F-1 divider; term flags the enabled edge on which it wraps.
module tick_prescaler #(
  parameter int F     = 100000000,
  parameter int PRE_W = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(F - 1);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  assign term = en && (cnt_q == LAST);

  // clr wins over en so start/stop always restart the period from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (term) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + PRE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tick_timer.sv
// Programmable tick counter: prescaled tick, one-shot/periodic terminal count,
// pause/resume, stop and restart, with registered tick/done strobes.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int F     = 100000000,
  parameter int PRE_W = 30,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] time_cnt,
  output logic             tick,
  output logic             done,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] time_cnt_q, time_cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             pre_clr, pre_en, pre_term;

  // The prescaler advances in RUN, and also on the HOLD->RUN edge itself.
  assign pre_clr = stop || start;
  assign pre_en  = (state_q != ST_IDLE) && !pause && !stop && !start;

  tick_prescaler #(.F(F), .PRE_W(PRE_W)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .term (pre_term)
  );

  always_comb begin
    state_d    = state_q;
    time_cnt_d = time_cnt_q;
    limit_d    = limit_q;
    mode_d     = mode_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d    = ST_RUN;
      time_cnt_d = '0;
      limit_d    = limit;
      mode_d     = mode;
    end else if (state_q != ST_IDLE) begin
      if (pause) begin
        state_d = ST_HOLD;
      end else begin
        state_d = ST_RUN;
        if (pre_term) begin
          if (time_cnt_q != limit_q) begin
            time_cnt_d = time_cnt_q + CNT_W'(1);
            tick_d     = 1'b1;
          end else if (mode_q == MODE_PERIODIC) begin
            time_cnt_d = '0;
            tick_d     = 1'b1;
            done_d     = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      time_cnt_q <= '0;
      limit_q    <= '0;
      mode_q     <= MODE_ONESHOT;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_cnt_q <= time_cnt_d;
      limit_q    <= limit_d;
      mode_q     <= mode_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign time_cnt = time_cnt_q;
  assign tick     = tick_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer with F=4, CNT_W=3; expected values hand-derived per edge.
module tb_tick_timer;

  localparam int F     = 4;
  localparam int PRE_W = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             pause = 1'b0;
  logic             mode = 1'b0;
  logic [CNT_W-1:0] limit = '0;
  logic [CNT_W-1:0] time_cnt;
  logic             tick, done, busy;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  tick_timer #(.F(F), .PRE_W(PRE_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .limit    (limit),
    .time_cnt (time_cnt),
    .tick     (tick),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, edge_n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Pulse start so that it is sampled on "edge 0".
  task automatic do_start(input logic m, input logic [CNT_W-1:0] l);
    start = 1'b1; mode = m; limit = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    edge_n = 0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int c, input int t, input int d, input int b);
    chk({tag, ".cnt"},  int'(time_cnt), c);
    chk({tag, ".tick"}, int'(tick), t);
    chk({tag, ".done"}, int'(done), d);
    chk({tag, ".busy"}, int'(busy), b);
  endtask

  initial begin
    #3;
    chk_all("reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    chk_all("idle", 0, 0, 0, 0);

    // Periodic, limit=7; mode/limit changes while busy must be ignored.
    do_start(1'b1, 3'd7);
    mode = 1'b0; limit = 3'd2;
    for (int e = 1; e <= 32; e++) begin
      step();
      chk_all("per7", (e / 4) % 8, (e % 4 == 0) ? 1 : 0, (e == 32) ? 1 : 0, 1);
    end
    do_stop();
    chk_all("per7.stop", 0, 0, 0, 0);

    // One-shot, limit=3.
    do_start(1'b0, 3'd3);
    for (int e = 1; e <= 20; e++) begin
      step();
      chk_all("one3", (e / 4 > 3) ? 3 : e / 4, (e % 4 == 0 && e <= 12) ? 1 : 0,
              (e == 16) ? 1 : 0, (e < 16) ? 1 : 0);
    end

    // Pause for edges 6..11 in periodic limit=7.
    do_start(1'b1, 3'd7);
    for (int e = 1; e <= 20; e++) begin
      int exp_c;
      if (e == 6) pause = 1'b1;
      if (e == 12) pause = 1'b0;
      step();
      exp_c = (e < 4) ? 0 : (e < 14) ? 1 : (e < 18) ? 2 : 3;
      chk_all("pause", exp_c, (e == 4 || e == 14 || e == 18) ? 1 : 0, 0, 1);
    end
    do_stop();

    // Stop coinciding with the one-shot terminal edge.
    do_start(1'b0, 3'd1);
    for (int e = 1; e <= 7; e++) step();
    chk_all("stop.pre", 1, 0, 0, 1);
    do_stop();
    chk_all("stop.term", 1, 0, 0, 0);
    for (int e = 0; e < 8; e++) step();
    chk_all("stop.hold", 1, 0, 0, 0);

    // Restart at edge 10 while time_cnt=2.
    do_start(1'b1, 3'd7);
    for (int e = 1; e <= 9; e++) step();
    chk_all("rst.pre", 2, 0, 0, 1);
    do_start(1'b1, 3'd7);
    chk_all("restart", 0, 0, 0, 1);
    for (int e = 1; e <= 4; e++) begin
      step();
      chk_all("restart.run", (e == 4) ? 1 : 0, (e == 4) ? 1 : 0, 0, 1);
    end

    // Asynchronous reset mid-cycle while tick is high.
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    chk_all("post_rst", 0, 0, 0, 0);

    // limit=0 periodic: done (and tick) every F edges, count stays 0.
    do_start(1'b1, 3'd0);
    for (int e = 1; e <= 13; e++) begin
      step();
      chk_all("lim0", 0, (e % 4 == 0) ? 1 : 0, (e % 4 == 0) ? 1 : 0, 1);
    end
    do_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
Name: tick_timer

Overview:
- Parametrised successor of the team's fixed 1 s LED-step counter.
- A prescaler divides `clk` by F to make a tick. An output counter of CNT_W bits advances once per tick, up to a limit that is programmable at start.
- Supports one-shot and periodic modes, pause/resume, explicit stop and restart, with tick and done strobes.
- Used by LED/segment display demos and by any lab block that needs second-scale or millisecond-scale sequencing.

Parameters:
- F, 100000000, clock cycles per tick; legal range 2 .. 2^PRE_W-1.
- PRE_W, 30, prescaler width in bits.
- CNT_W, 3, width of the tick counter and of the limit.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse; latches limit and mode, clears counters, enters RUN.
- stop  input  1  pulse; abort to IDLE, time_cnt holds its value.
- pause  input  1  level; while high in RUN the block freezes (HOLD).
- mode  input  1  0 = one-shot, 1 = periodic; sampled only on start.
- limit  input  CNT_W  terminal count; sampled only on start.
- time_cnt  output  CNT_W  current tick count, registered.
- tick  output  1  registered one-cycle pulse in the cycle time_cnt changes due to a tick.
- done  output  1  registered one-cycle pulse when the terminal count is reached.
- busy  output  1  high in RUN or HOLD.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, prescaler=0, time_cnt=0, tick=0, done=0, busy=0.
  - limit_r=0, mode_r=0.
  - Deassertion takes effect at the next edge.
- States: IDLE, RUN, HOLD. busy = (state != IDLE), registered.
- Input priority per edge: stop > start > pause.
  - stop in any state: go to IDLE, prescaler=0, time_cnt unchanged, no tick/done that edge even if the terminal count coincides.
  - start (no stop) in any state: prescaler=0, time_cnt=0, limit_r=limit, mode_r=mode, go to RUN. A start during RUN/HOLD is a restart.
  - RUN with pause=1: go to HOLD. prescaler and time_cnt are frozen from this edge onward; no increment occurs on this edge.
  - HOLD with pause=0: return to RUN; counting resumes from the frozen prescaler value.
- Prescaler:
  - In RUN it counts 0..F-1.
  - At an edge where prescaler==F-1 it wraps to 0 and a tick event occurs.
  - The first tick event is F edges after the start edge.
- Tick event, evaluated on that edge:
  - time_cnt != limit_r: time_cnt+1, tick=1.
  - time_cnt == limit_r and mode_r=1 (periodic): time_cnt=0, tick=1, done=1, stay in RUN.
  - time_cnt == limit_r and mode_r=0 (one-shot): time_cnt holds, tick=0, done=1, go to IDLE.
- Arithmetic: counters are unsigned, so time_cnt can never exceed limit_r. limit=0 behaves as follows:
  - one-shot: done after F cycles.
  - periodic: a done every F cycles, time_cnt stays 0.
- tick and done are 0 in every cycle not described above; they are never asserted in IDLE or HOLD.
- Changes to mode/limit while busy have no effect until the next start.

Decomposition:
- Package tick_timer_pkg holds:
  - the state enum (IDLE, RUN, HOLD);
  - mode constants MODE_ONESHOT=0 and MODE_PERIODIC=1.
- One sub-module, tick_prescaler:
  - parameters F and PRE_W;
  - inputs clk, rst, clr, en;
  - output term (prescaler==F-1 and en);
  - owns the PRE_W-bit counter.
- The FSM, limit/mode latches and time_cnt stay in tick_timer.

Test Plan (F=4, CNT_W=3):
- Periodic, limit=7: start at edge 0 → tick at edges 4, 8 … 28 with time_cnt 1..7. At edge 32, time_cnt=0 with tick=1, done=1, busy stays 1.
- One-shot, limit=3: start at edge 0 → time_cnt=3 at edge 12, done=1 at edge 16, busy=0 after edge 16, time_cnt holds 3, no further ticks.
- Pause, periodic, limit=7: pause high for edges 6..11 → busy stays 1, no ticks during HOLD. Ticks land at edges 4, 14, 18; time_cnt=1 throughout the pause.
- Stop on the terminal edge, one-shot, limit=1: stop asserted at edge 8 → done=0, tick=0, state IDLE, time_cnt holds 1.
- Restart and reset:
  - start at edge 10 while time_cnt=2 (limit=7 periodic) → time_cnt=0, next tick at edge 14.
  - rst pulsed asynchronously between edges → all outputs 0 immediately, IDLE.
- limit=0 periodic: done pulses at edges 4, 8, 12; time_cnt constant 0.
